// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with dual write, forwarding and busy scoreboard
module regfile_mp #(
  parameter int REG_WIDTH = 64,
  parameter int NUM_REGS  = 32,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_RD*AW-1:0]        rs_addr,
  output logic [NUM_RD*REG_WIDTH-1:0] rs_dout,
  output logic [NUM_RD-1:0]           rs_busy,
  input  logic                        we0,
  input  logic [AW-1:0]               wa0,
  input  logic [REG_WIDTH-1:0]        wd0,
  input  logic                        we1,
  input  logic [AW-1:0]               wa1,
  input  logic [REG_WIDTH-1:0]        wd1,
  input  logic                        set_busy,
  input  logic [AW-1:0]               set_addr,
  output logic                        init_done
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam logic [AW:0] CNT_LAST = (AW+1)'(NUM_REGS - 1);

  state_t               state, state_nxt;
  logic [AW:0]          cnt;
  logic [NUM_REGS-1:0]  busy, busy_nxt;
  logic [REG_WIDTH-1:0] mem [NUM_REGS];

  // Writes to entry 0 are discarded when it is hard-wired zero.
  logic wr0_ok, wr1_ok, set_ok;
  assign wr0_ok = we0 && !((ZERO_REG != 0) && (wa0 == '0));
  assign wr1_ok = we1 && !((ZERO_REG != 0) && (wa1 == '0));
  assign set_ok = set_busy && !((ZERO_REG != 0) && (set_addr == '0));

  assign init_done = (state == RUN);

  // Control state: FSM, clear counter and scoreboard bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= '0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      if (state == CLEAR) cnt <= cnt + (AW+1)'(1);
    end
  end

  // Next state and scoreboard update; a set beats a same-cycle clear.
  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    if (state == CLEAR) begin
      if (cnt == CNT_LAST) state_nxt = RUN;
    end else begin
      if (wr0_ok) busy_nxt[wa0] = 1'b0;
      if (wr1_ok) busy_nxt[wa1] = 1'b0;
      if (set_ok) busy_nxt[set_addr] = 1'b1;
    end
  end

  // Storage: zero-fill during CLEAR, then two write lanes with lane 1 last so it wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[cnt[AW-1:0]] <= '0;
      end else begin
        if (wr0_ok) mem[wa0] <= wd0;
        if (wr1_ok) mem[wa1] <= wd1;
      end
    end
  end

  // Read ports: zero register, then lane 1, lane 0, then storage.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit0, hit1, zero_hit;
    assign a        = rs_addr[i*AW +: AW];
    assign hit1     = we1 && (wa1 == a);
    assign hit0     = we0 && (wa0 == a);
    assign zero_hit = (ZERO_REG != 0) && (a == '0);
    assign rs_dout[i*REG_WIDTH +: REG_WIDTH] =
      (!init_done || zero_hit) ? '0 : hit1 ? wd1 : hit0 ? wd0 : mem[a];
    assign rs_busy[i] = init_done && busy[a] && !(hit0 || hit1);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp against a behavioural model
module tb_regfile_mp;
  localparam int W  = 64;
  localparam int N  = 32;
  localparam int R  = 3;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [R*AW-1:0] rs_addr;
  logic [R*W-1:0]  rs_dout;
  logic [R-1:0]    rs_busy;
  logic            we0, we1, set_busy;
  logic [AW-1:0]   wa0, wa1, set_addr;
  logic [W-1:0]    wd0, wd1;
  logic            init_done;

  regfile_mp #(.REG_WIDTH(W), .NUM_REGS(N), .NUM_RD(R), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_dout(rs_dout), .rs_busy(rs_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .set_busy(set_busy), .set_addr(set_addr), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [R*W-1:0] dout;
    logic [R-1:0]   busy;
    logic           done;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: architectural contents, busy flags, edges since reset release.
  logic [W-1:0] m_mem [N];
  bit           m_busy [N];
  int           m_edges = 0;
  bit           m_done = 1'b0;

  task automatic cyc(input bit r, input bit e0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                     input bit e1, input logic [AW-1:0] a1, input logic [W-1:0] d1,
                     input bit sb, input logic [AW-1:0] sa,
                     input logic [AW-1:0] p0, input logic [AW-1:0] p1, input logic [AW-1:0] p2);
    exp_t          e;
    logic [AW-1:0] pa [R];
    @(posedge clk); #1;
    reset = r; we0 = e0; wa0 = a0; wd0 = d0; we1 = e1; wa1 = a1; wd1 = d1;
    set_busy = sb; set_addr = sa; rs_addr = {p2, p1, p0};
    pa[0] = p0; pa[1] = p1; pa[2] = p2;
    e.dout = '0; e.busy = '0; e.done = m_done;
    if (m_done) begin
      for (int i = 0; i < R; i++) begin
        logic [W-1:0] v;
        bit h0, h1;
        h1 = e1 && (a1 == pa[i]);
        h0 = e0 && (a0 == pa[i]);
        if (pa[i] == 0) v = '0;
        else if (h1)    v = d1;
        else if (h0)    v = d0;
        else            v = m_mem[pa[i]];
        e.dout[i*W +: W] = v;
        e.busy[i] = m_busy[pa[i]] && !(h0 || h1);
      end
    end
    expq.push_back(e);
    if (r) begin
      m_edges = 0; m_done = 1'b0;
      for (int k = 0; k < N; k++) m_busy[k] = 1'b0;
    end else if (!m_done) begin
      m_edges++;
      if (m_edges == N) begin
        m_done = 1'b1;
        for (int k = 0; k < N; k++) m_mem[k] = '0;
      end
    end else begin
      if (e0 && a0 != 0) begin m_mem[a0] = d0; m_busy[a0] = 1'b0; end
      if (e1 && a1 != 0) begin m_mem[a1] = d1; m_busy[a1] = 1'b0; end
      if (sb && sa != 0) m_busy[sa] = 1'b1;
    end
  endtask

  task automatic rd(input logic [AW-1:0] p0, input logic [AW-1:0] p1, input logic [AW-1:0] p2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, p0, p1, p2);
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (init_done !== e.done) begin
        errors++;
        $display("FAIL init_done t=%0t got=%0b want=%0b", $time, init_done, e.done);
      end
      for (int i = 0; i < R; i++) begin
        checks++;
        if (rs_dout[i*W +: W] !== e.dout[i*W +: W]) begin
          errors++;
          $display("FAIL rs_dout[%0d] t=%0t got=%h want=%h", i, $time, rs_dout[i*W +: W], e.dout[i*W +: W]);
        end
        checks++;
        if (rs_busy[i] !== e.busy[i]) begin
          errors++;
          $display("FAIL rs_busy[%0d] t=%0t got=%0b want=%0b", i, $time, rs_busy[i], e.busy[i]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; we0 = 0; we1 = 0; set_busy = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; set_addr = 0; rs_addr = '0;
    for (int k = 0; k < N; k++) begin m_mem[k] = '0; m_busy[k] = 1'b0; end

    // Reset for two cycles, then the clear sequence with ignored writes/sets late in it.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    for (int k = 0; k < N; k++) begin
      if (k >= 20 && k < 30)
        cyc(0, 1, AW'(k - 19), {$urandom, $urandom}, 1, AW'(k - 10), {$urandom, $urandom},
            1, AW'(k - 19), AW'(k - 19), 5, 7);
      else
        rd(1, 2, 3);
    end
    // All entries zero after clear.
    for (int k = 0; k < N; k += 3) rd(AW'(k), AW'(k + 1), AW'(k + 2));

    // Dual write same address: lane 1 wins, same cycle and after.
    cyc(0, 1, 5, 64'hAAAA, 1, 5, 64'hBBBB, 0, 0, 5, 5, 6);
    rd(5, 4, 6);

    // Zero register ignores writes and busy-sets.
    cyc(0, 1, 0, 64'h1234, 0, 0, 0, 1, 0, 0, 0, 0);
    rd(0, 0, 5);

    // Scoreboard on x7: set, clear by write, then set racing a clear.
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 7, 7);
    rd(7, 7, 7);
    cyc(0, 1, 7, 64'h77, 0, 0, 0, 0, 0, 7, 7, 7);
    rd(7, 7, 7);
    cyc(0, 0, 0, 0, 1, 7, 64'h7070, 1, 7, 7, 7, 7);
    rd(7, 7, 7);

    // Forwarding across three ports.
    cyc(0, 1, 3, 64'h11, 1, 4, 64'h22, 0, 0, 3, 3, 4);
    rd(3, 4, 3);

    // Reset mid-operation: x9 written and busy, then cleared by a full sequence.
    cyc(0, 1, 9, 64'hFF, 0, 0, 0, 1, 9, 9, 9, 9);
    rd(9, 9, 9);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 9);
    for (int k = 0; k < N + 2; k++) rd(9, 9, 8);

    // Randomised traffic over a narrow address window, with rare resets.
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 149) == 0),
          $urandom_range(0, 1), AW'($urandom_range(0, 9)), {$urandom, $urandom},
          $urandom_range(0, 1), AW'($urandom_range(0, 9)), {$urandom, $urandom},
          $urandom_range(0, 1), AW'($urandom_range(0, 9)),
          AW'($urandom_range(0, 9)), AW'($urandom_range(0, 9)), AW'($urandom_range(0, 31)));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the pipelined RISC-V core. It generalises the existing 2-read/1-write register file to a configurable register width, register count and number of read ports, and adds a second write port and a per-register busy scoreboard for hazard detection. It also adds a hardware clear sequence after reset, so simulation and synthesis start from a known all-zero state without a memory preload. It sits between decode (reads, scoreboard set) and writeback (two retire lanes).

## Interface
- REG_WIDTH, 64, data width of each register
- NUM_REGS, 32, number of entries (power of two, ≥ 2); AW = $clog2(NUM_REGS)
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 entry 0 is hard-wired zero (reads 0, writes and busy-sets ignored)

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rs_addr  in  NUM_RD*AW  read addresses, port i at [i*AW +: AW]
- rs_dout  out  NUM_RD*REG_WIDTH  read data, port i at [i*REG_WIDTH +: REG_WIDTH]
- rs_busy  out  NUM_RD  scoreboard busy flag for each read address
- we0 / wa0 / wd0  in  1 / AW / REG_WIDTH  write port 0 (older retire lane)
- we1 / wa1 / wd1  in  1 / AW / REG_WIDTH  write port 1 (younger lane, higher priority)
- set_busy  in  1  mark register set_addr as having an in-flight producer
- set_addr  in  AW  register to mark busy
- init_done  out  1  high once the clear sequence has finished; writes, busy-sets and reads are honoured only while high

## Operation
- FSM states: CLEAR, RUN.
- On reset: the FSM enters CLEAR, the clear counter is set to 0, and all busy bits are set to 0.
- In CLEAR:
  - Each edge writes 0 to entry cnt, then increments cnt.
  - The edge at which cnt == NUM_REGS-1 moves the FSM to RUN.
  - we0, we1 and set_busy are ignored.
  - rs_dout reads as all zeros and rs_busy reads as 0.
- Reset asserted mid-CLEAR or in RUN restarts the sequence from cnt = 0.
- Writes in RUN:
  - A port writes wdN to entry waN at the edge when weN = 1.
  - If both ports write the same address, port 1's data is stored.
  - When ZERO_REG = 1, a write to address 0 is dropped.
- Reads with internal forwarding, per read port, in priority order:
  1. Address 0 with ZERO_REG = 1 returns 0.
  2. Otherwise, if we1 is high and wa1 matches, return wd1.
  3. Otherwise, if we0 is high and wa0 matches, return wd0.
  4. Otherwise, return the stored entry.
- Scoreboard in RUN:
  - A write on either port clears busy[waN] at the edge.
  - set_busy sets busy[set_addr] at the edge.
  - If a set and a clear hit the same address in the same cycle, the set wins (new producer issued).
  - set_busy to address 0 is ignored when ZERO_REG = 1.
- rs_busy[i] = busy[addr_i] AND NOT (a same-cycle write to addr_i). This keeps the flag consistent with forwarded data.

## Timing
- Reset values: init_done = 0, rs_busy = 0, rs_dout = 0, every busy bit = 0.
- Clear sequence length:
  - After reset is released, init_done rises after exactly NUM_REGS rising edges.
  - For example, with NUM_REGS = 32, reset low at edge 0 gives init_done = 1 after edge 31.
- Read latency is 0 cycles (combinational from rs_addr, the write ports and the stored state).
- A written value is visible on rs_dout in the same cycle via forwarding and from storage on every later cycle.
- A busy-set at edge N gives rs_busy = 1 from cycle N+1.
- A clear is visible on rs_busy in the same cycle via the write-match mask, and from storage from cycle N+1.
- Arithmetic and address rules: no arithmetic on data. The clear counter is AW+1 bits and does not wrap in CLEAR. Addresses ≥ NUM_REGS cannot occur because AW bits exactly cover the entries.

## Test plan
- Clear sequence (NUM_REGS = 32): assert reset for 2 cycles, then release. Required:
  - init_done = 0 for 31 edges and becomes 1 after the 32nd.
  - All 32 entries read 0.
  - A we0 pulse during CLEAR does not change any entry.
- Dual write, same address: we0 = we1 = 1, wa0 = wa1 = 5, wd0 = 0xAAAA, wd1 = 0xBBBB. Required:
  - rs_dout for address 5 = 0xBBBB in the same cycle.
  - x5 = 0xBBBB on the next cycle.
- Zero register: write 0x1234 to x0 and set_busy x0. Required: x0 reads 0 in the same and next cycles, with rs_busy = 0.
- Scoreboard: set_busy x7 at edge N. Required:
  - rs_busy = 1 from cycle N+1.
  - we0 with wa0 = 7 at cycle M forces rs_busy = 0 in cycle M.
  - busy stays 0 from M+1.
  - A simultaneous set_busy x7 plus we1 wa1 = 7 leaves busy = 1.
- Forwarding priority with NUM_RD = 3: ports read x3, x3, x4 while we0 writes x3 = 0x11 and we1 writes x4 = 0x22. Required outputs: 0x11, 0x11, 0x22.
- Reset mid-operation: x9 = 0xFF and busy[9] = 1. Assert reset for 1 cycle. Required:
  - Busy bits are cleared on the reset edge.
  - init_done drops to 0.
  - After a full clear sequence, x9 reads 0.
